// File: rtl/hub75_bank_ctrl.sv
// rtl/hub75_bank_ctrl.sv - ping-pong frame-buffer bank controller for a HUB75 panel
module hub75_bank_ctrl #(
    parameter int hpixel_p       = 64,
    parameter int vpixel_p       = 64,
    parameter int bpp_p          = 8,
    parameter int frame_cnt_wd_p = 16,
    localparam int addr_width_p  = $clog2(hpixel_p * vpixel_p)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_enable,
    input  logic                      i_frame_done,
    input  logic [addr_width_p-1:0]   i_wr_addr,
    input  logic [3*bpp_p-1:0]        i_wr_data,
    input  logic                      i_wr_en,
    output logic                      o_wr_ready,
    output logic                      o_wr_drop,
    input  logic                      i_swap_req,
    output logic                      o_swap_done,
    output logic                      o_mem_wr_en,
    output logic [addr_width_p:0]     o_mem_wr_addr,
    output logic [3*bpp_p-1:0]        o_mem_wr_data,
    input  logic [addr_width_p-1:0]   i_rd_addr,
    output logic [addr_width_p:0]     o_mem_rd_addr,
    output logic                      o_rd_bank,
    output logic [frame_cnt_wd_p-1:0] o_frame_cnt
);

    typedef enum logic [1:0] {
        SHOW = 2'd0,
        PEND = 2'd1,
        SWAP = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   rd_bank;
    logic   wr_bank;
    logic   wr_accept;

    // Back bank is always the complement of the front bank.
    assign wr_bank       = ~rd_bank;
    assign o_rd_bank     = rd_bank;
    assign o_mem_rd_addr = {rd_bank, i_rd_addr};
    assign wr_accept     = i_wr_en & o_wr_ready;

    always_comb begin
        next_state = state;
        case (state)
            SHOW: begin
                if (i_swap_req) begin
                    next_state = (i_frame_done || !i_enable) ? SWAP : PEND;
                end
            end
            PEND: begin
                if (i_frame_done || !i_enable) begin
                    next_state = SWAP;
                end
            end
            SWAP:    next_state = SHOW;
            default: next_state = SHOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SHOW;
            rd_bank       <= 1'b0;
            o_wr_ready    <= 1'b1;
            o_wr_drop     <= 1'b0;
            o_swap_done   <= 1'b0;
            o_frame_cnt   <= '0;
            o_mem_wr_en   <= 1'b0;
            o_mem_wr_addr <= '0;
            o_mem_wr_data <= '0;
        end else begin
            state       <= next_state;
            // Ready follows the next state so it drops right after a request is taken.
            o_wr_ready  <= (next_state == SHOW);
            o_swap_done <= (state == SWAP);
            if (state == SWAP) begin
                rd_bank     <= ~rd_bank;
                o_frame_cnt <= o_frame_cnt + 1'b1;
            end
            o_mem_wr_en <= wr_accept;
            o_wr_drop   <= i_wr_en & ~o_wr_ready;
            if (wr_accept) begin
                o_mem_wr_addr <= {wr_bank, i_wr_addr};
                o_mem_wr_data <= i_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_hub75_bank_ctrl.sv
// tb/tb_hub75_bank_ctrl.sv - directed vector bench for hub75_bank_ctrl
module tb_hub75_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable;
    logic        i_frame_done;
    logic [11:0] i_wr_addr;
    logic [23:0] i_wr_data;
    logic        i_wr_en;
    logic        o_wr_ready;
    logic        o_wr_drop;
    logic        i_swap_req;
    logic        o_swap_done;
    logic        o_mem_wr_en;
    logic [12:0] o_mem_wr_addr;
    logic [23:0] o_mem_wr_data;
    logic [11:0] i_rd_addr;
    logic [12:0] o_mem_rd_addr;
    logic        o_rd_bank;
    logic [15:0] o_frame_cnt;

    int checks = 0;
    int errors = 0;

    hub75_bank_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (i_enable),
        .i_frame_done (i_frame_done),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
        .i_wr_en      (i_wr_en),
        .o_wr_ready   (o_wr_ready),
        .o_wr_drop    (o_wr_drop),
        .i_swap_req   (i_swap_req),
        .o_swap_done  (o_swap_done),
        .o_mem_wr_en  (o_mem_wr_en),
        .o_mem_wr_addr(o_mem_wr_addr),
        .o_mem_wr_data(o_mem_wr_data),
        .i_rd_addr    (i_rd_addr),
        .o_mem_rd_addr(o_mem_rd_addr),
        .o_rd_bank    (o_rd_bank),
        .o_frame_cnt  (o_frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        fd;
        logic        wen;
        logic [11:0] wa;
        logic [23:0] wd;
        logic        sr;
        logic [11:0] ra;
        logic        rdy;
        logic        drop;
        logic        sd;
        logic        mwen;
        logic [12:0] ma;
        logic [23:0] md;
        logic        rb;
        logic [15:0] fc;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic r, input logic en, input logic fd, input logic wen,
                                input logic [11:0] wa, input logic [23:0] wd, input logic sr,
                                input logic [11:0] ra, input logic rdy, input logic drop,
                                input logic sd, input logic mwen, input logic [12:0] ma,
                                input logic [23:0] md, input logic rb, input logic [15:0] fc);
        vec_t v;
        v.rst = r;   v.en = en;     v.fd = fd;   v.wen = wen;
        v.wa = wa;   v.wd = wd;     v.sr = sr;   v.ra = ra;
        v.rdy = rdy; v.drop = drop; v.sd = sd;   v.mwen = mwen;
        v.ma = ma;   v.md = md;     v.rb = rb;   v.fc = fc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        rst          = v.rst;
        i_enable     = v.en;
        i_frame_done = v.fd;
        i_wr_en      = v.wen;
        i_wr_addr    = v.wa;
        i_wr_data    = v.wd;
        i_swap_req   = v.sr;
        i_rd_addr    = v.ra;
    endtask

    initial begin
        //               rst en fd wen wa      wd          sr ra      rdy drp sd mwe ma       md          rb fc
        vecs[0]  = mk(1, 1, 0, 0, 12'h000, 24'h000000, 0, 12'h000, 1, 0, 0, 0, 13'h0000, 24'h000000, 0, 16'd0);
        vecs[1]  = mk(0, 1, 0, 0, 12'h000, 24'h000000, 0, 12'h000, 1, 0, 0, 0, 13'h0000, 24'h000000, 0, 16'd0);
        vecs[2]  = mk(0, 1, 0, 1, 12'h010, 24'hFF0000, 0, 12'h000, 1, 0, 0, 1, 13'h1010, 24'hFF0000, 0, 16'd0);
        vecs[3]  = mk(0, 1, 0, 1, 12'hFFF, 24'h123456, 0, 12'h0AB, 1, 0, 0, 1, 13'h1FFF, 24'h123456, 0, 16'd0);
        vecs[4]  = mk(0, 1, 0, 1, 12'h020, 24'h00FF00, 1, 12'h000, 0, 0, 0, 1, 13'h1020, 24'h00FF00, 0, 16'd0);
        vecs[5]  = mk(0, 1, 0, 1, 12'h021, 24'h111111, 0, 12'h000, 0, 1, 0, 0, 13'h0000, 24'h000000, 0, 16'd0);
        vecs[6]  = mk(0, 1, 0, 0, 12'h000, 24'h000000, 1, 12'h000, 0, 0, 0, 0, 13'h0000, 24'h000000, 0, 16'd0);
        vecs[7]  = mk(0, 1, 1, 1, 12'h022, 24'h222222, 0, 12'h000, 0, 1, 0, 0, 13'h0000, 24'h000000, 0, 16'd0);
        vecs[8]  = mk(0, 1, 0, 0, 12'h000, 24'h000000, 0, 12'h005, 1, 0, 1, 0, 13'h0000, 24'h000000, 1, 16'd1);
        vecs[9]  = mk(0, 1, 0, 0, 12'h000, 24'h000000, 0, 12'h005, 1, 0, 0, 0, 13'h0000, 24'h000000, 1, 16'd1);
        vecs[10] = mk(0, 1, 0, 1, 12'h030, 24'h0000FF, 0, 12'h000, 1, 0, 0, 1, 13'h0030, 24'h0000FF, 1, 16'd1);
        vecs[11] = mk(0, 1, 1, 0, 12'h000, 24'h000000, 0, 12'h000, 1, 0, 0, 0, 13'h0000, 24'h000000, 1, 16'd1);
        vecs[12] = mk(0, 0, 0, 0, 12'h000, 24'h000000, 1, 12'h000, 0, 0, 0, 0, 13'h0000, 24'h000000, 1, 16'd1);
        vecs[13] = mk(0, 0, 0, 0, 12'h000, 24'h000000, 0, 12'h7FF, 1, 0, 1, 0, 13'h0000, 24'h000000, 0, 16'd2);
        vecs[14] = mk(0, 1, 1, 1, 12'h040, 24'hABCDEF, 1, 12'h000, 0, 0, 0, 1, 13'h1040, 24'hABCDEF, 0, 16'd2);
        vecs[15] = mk(0, 1, 0, 0, 12'h000, 24'h000000, 0, 12'h000, 1, 0, 1, 0, 13'h0000, 24'h000000, 1, 16'd3);
        vecs[16] = mk(0, 1, 0, 0, 12'h000, 24'h000000, 1, 12'h000, 0, 0, 0, 0, 13'h0000, 24'h000000, 1, 16'd3);
        vecs[17] = mk(1, 1, 0, 0, 12'h000, 24'h000000, 0, 12'h000, 1, 0, 0, 0, 13'h0000, 24'h000000, 0, 16'd0);
        vecs[18] = mk(0, 1, 1, 0, 12'h000, 24'h000000, 0, 12'h000, 1, 0, 0, 0, 13'h0000, 24'h000000, 0, 16'd0);
        vecs[19] = mk(0, 1, 0, 0, 12'h000, 24'h000000, 0, 12'h000, 1, 0, 0, 0, 13'h0000, 24'h000000, 0, 16'd0);

        drive(vecs[0]);
        #1;
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i]);
            tick();
            chk($sformatf("v%0d wr_ready", i),  o_wr_ready,  vecs[i].rdy);
            chk($sformatf("v%0d wr_drop", i),   o_wr_drop,   vecs[i].drop);
            chk($sformatf("v%0d swap_done", i), o_swap_done, vecs[i].sd);
            chk($sformatf("v%0d mem_wr_en", i), o_mem_wr_en, vecs[i].mwen);
            chk($sformatf("v%0d rd_bank", i),   o_rd_bank,   vecs[i].rb);
            chk($sformatf("v%0d frame_cnt", i), o_frame_cnt, vecs[i].fc);
            chk($sformatf("v%0d mem_rd_addr", i), o_mem_rd_addr, {vecs[i].rb, vecs[i].ra});
            if (vecs[i].mwen || vecs[i].rst) begin
                chk($sformatf("v%0d mem_wr_addr", i), o_mem_wr_addr, vecs[i].ma);
                chk($sformatf("v%0d mem_wr_data", i), o_mem_wr_data, vecs[i].md);
            end
        end

        // Long frame: request at cycle 10, blocked write at 20, frame boundary at 40.
        drive(vecs[0]);
        tick();
        drive(vecs[1]);
        i_rd_addr = 12'h123;
        for (int c = 0; c < 44; c++) begin
            i_swap_req   = (c == 10);
            i_wr_en      = (c == 20);
            i_wr_addr    = 12'h055;
            i_wr_data    = 24'h00AA00;
            i_frame_done = (c == 40);
            tick();
            if (c + 1 == 11) chk("long wr_ready low", o_wr_ready, 1'b0);
            if (c + 1 == 21) begin
                chk("long wr_drop", o_wr_drop, 1'b1);
                chk("long no mem_wr_en", o_mem_wr_en, 1'b0);
            end
            if (c + 1 >= 11 && c + 1 <= 41) chk($sformatf("long front hold c%0d", c + 1), o_rd_bank, 1'b0);
            if (c + 1 == 41) chk("long no early done", o_swap_done, 1'b0);
            if (c + 1 == 42) begin
                chk("long rd_bank", o_rd_bank, 1'b1);
                chk("long swap_done", o_swap_done, 1'b1);
                chk("long wr_ready back", o_wr_ready, 1'b1);
                chk("long frame_cnt", o_frame_cnt, 16'd1);
                chk("long rd_addr msb", o_mem_rd_addr, 13'h1123);
            end
            if (c + 1 == 43) chk("long done pulse width", o_swap_done, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
